hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_sb.sv | 43 ++++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizing for the decode-stage hazard controller.
// Optional forwarding behaviour is selected with HAZARD_CTRL_FWD_EN.
package hazard_pkg;

    localparam int unsigned REG_AW       = 3;
    localparam int unsigned SB_DEPTH     = 3;
    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned CNT_W        = 2;

    // Controller mode: normal issue, pipeline drain after halt/err, halted
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // One in-flight register writer tracked by the scoreboard
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              load;
    } slot_t;

    // True when the decoded instruction reads the register this slot will write
    function automatic logic slot_match(
        input slot_t             s,
        input logic [REG_AW-1:0] rs_addr,
        input logic              rs_used,
        input logic [REG_AW-1:0] rt_addr,
        input logic              rt_used
    );
        return s.valid & ((rs_used & (rs_addr == s.rd)) |
                          (rt_used & (rt_addr == s.rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage view presented to the hazard controller and its pipeline controls.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs_addr;
    logic              id_rs_used;
    logic [REG_AW-1:0] id_rt_addr;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_branch;
    logic              id_is_branch;
    logic              id_halt;
    logic              id_err;

    logic              stall_if;
    logic              bubble_ex;
    logic              flush_if;
    logic              halt;
    logic              err;

    // Pipeline side: drives decode information, consumes control outputs
    modport master (
        output id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
        output id_rd_addr, id_reg_write, id_mem_read, id_branch, id_is_branch,
        output id_halt, id_err,
        input  stall_if, bubble_ex, flush_if, halt, err
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
        input  id_rd_addr, id_reg_write, id_mem_read, id_branch, id_is_branch,
        input  id_halt, id_err,
        output stall_if, bubble_ex, flush_if, halt, err
    );

endinterface

// File: rtl/hazard_sb.sv
// Three-stage (EX, MEM, WB) writer scoreboard with source-match outputs
// for the EX and MEM slots; WB is covered by the register-file bypass.
module hazard_sb
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  slot_t             push,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rt_used,
    output logic              match_ex,
    output logic              match_mem,
    output logic              load_ex,
    output logic              load_mem
);

    slot_t sb [SB_DEPTH];

    // Shift EX -> MEM -> WB every cycle; WB falls off on the next shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= push;
            for (int i = 1; i < int'(SB_DEPTH); i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Source-operand matches against the writers still ahead of the bypass
    always_comb begin
        match_ex  = slot_match(sb[0], rs_addr, rs_used, rt_addr, rt_used);
        match_mem = slot_match(sb[1], rs_addr, rs_used, rt_addr, rt_used);
        load_ex   = sb[0].load;
        load_mem  = sb[1].load;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW stall/bubble, branch flush and a
// halt/error drain sequence. Define HAZARD_CTRL_FWD_EN for the forwarding
// pipeline variant (only load-use and branch-operand hazards stall).
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);

    state_e             state;
    state_e             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               err_q;
    logic               err_nx;

    logic               match_ex;
    logic               match_mem;
    logic               load_ex;
    logic               load_mem;
    logic               hazard;
    logic               run;
    slot_t              push;

    assign run = (state == ST_RUN);

`ifdef HAZARD_CTRL_FWD_EN
    // ALU results forward from EX/MEM; loads and decode-resolved branches cannot use them
    assign hazard = bus.id_valid &
                    ((match_ex  & (load_ex | bus.id_is_branch)) |
                     (match_mem & load_mem & bus.id_is_branch));
`else
    // No forwarding: any writer still in EX or MEM blocks the reader
    assign hazard = bus.id_valid & (match_ex | match_mem);

    logic unused_fwd;
    assign unused_fwd = ^{bus.id_is_branch, load_ex, load_mem};
`endif

    // Only an instruction that actually leaves decode becomes a tracked writer
    always_comb begin
        push       = '0;
        push.valid = bus.id_valid & bus.id_reg_write & ~hazard & run;
        push.rd    = bus.id_rd_addr;
        push.load  = bus.id_mem_read;
    end

    hazard_sb u_sb (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .rs_addr   (bus.id_rs_addr),
        .rs_used   (bus.id_rs_used),
        .rt_addr   (bus.id_rt_addr),
        .rt_used   (bus.id_rt_used),
        .match_ex  (match_ex),
        .match_mem (match_mem),
        .load_ex   (load_ex),
        .load_mem  (load_mem)
    );

    // Mode, drain counter and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    // Next mode and same-cycle pipeline controls
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        err_nx        = err_q;
        bus.stall_if  = 1'b0;
        bus.bubble_ex = 1'b0;
        bus.flush_if  = 1'b0;
        bus.halt      = 1'b0;
        bus.err       = err_q;

        case (state)
            ST_RUN: begin
                bus.stall_if  = hazard;
                bus.bubble_ex = hazard;
                bus.flush_if  = bus.id_valid & bus.id_branch & ~hazard;
                if (bus.id_valid & (bus.id_halt | bus.id_err) & ~hazard) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = CNT_W'(DRAIN_CYCLES);
                    err_nx   = err_q | bus.id_err;
                end
            end
            ST_DRAIN: begin
                bus.stall_if  = 1'b1;
                bus.bubble_ex = 1'b1;
                cnt_nx        = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = ST_HALT;
                end
            end
            ST_HALT: begin
                bus.stall_if  = 1'b1;
                bus.bubble_ex = 1'b1;
                bus.halt      = 1'b1;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        // Decode inputs are not trusted while reset is held
        if (!rst) begin
            bus.stall_if  = 1'b0;
            bus.bubble_ex = 1'b0;
            bus.flush_if  = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: reference model built on a time-stamped
// log of issued register writes; a negedge monitor compares every cycle.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit       valid;
        bit [2:0] rs;
        bit       rs_used;
        bit [2:0] rt;
        bit       rt_used;
        bit [2:0] rd;
        bit       reg_write;
        bit       mem_read;
        bit       branch;
        bit       is_branch;
        bit       halt;
        bit       err;
    } dec_t;

    typedef struct {
        bit stall;
        bit bubble;
        bit flush;
        bit halt;
        bit err;
    } exp_t;

    typedef struct {
        int       cyc;
        bit [2:0] rd;
        bit       load;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if bus();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    wr_t  wr_log[$];
    int   cyc      = 0;
    int   drain_at = -1;
    bit   m_err    = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   mon_cyc  = 0;

    function automatic void chk(input string nm, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (monitor cycle %0d)", nm, act, expv, mon_cyc);
        end
    endfunction

    function automatic void chk_int(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    function automatic dec_t nop();
        dec_t d = '{default: 0};
        return d;
    endfunction

    function automatic dec_t alu(input bit [2:0] rd, input bit [2:0] rs, input bit [2:0] rt);
        dec_t d = nop();
        d.valid = 1; d.rd = rd; d.reg_write = 1;
        d.rs = rs; d.rs_used = 1; d.rt = rt; d.rt_used = 1;
        return d;
    endfunction

    function automatic dec_t ld(input bit [2:0] rd, input bit [2:0] rs);
        dec_t d = nop();
        d.valid = 1; d.rd = rd; d.reg_write = 1; d.mem_read = 1;
        d.rs = rs; d.rs_used = 1;
        return d;
    endfunction

    function automatic dec_t br(input bit [2:0] rs, input bit taken);
        dec_t d = nop();
        d.valid = 1; d.rs = rs; d.rs_used = 1; d.is_branch = 1; d.branch = taken;
        return d;
    endfunction

    function automatic dec_t stop(input bit h, input bit e);
        dec_t d = nop();
        d.valid = 1; d.halt = h; d.err = e;
        return d;
    endfunction

    // Reader is blocked by a logged write 1 (EX) or 2 (MEM) cycles old
    function automatic bit model_hazard(input dec_t d);
        bit h = 0;
        foreach (wr_log[i]) begin
            int age = cyc - wr_log[i].cyc;
            bit hit = (d.rs_used && d.rs == wr_log[i].rd) || (d.rt_used && d.rt == wr_log[i].rd);
            if (hit) begin
                if (!FWD) begin
                    if (age == 1 || age == 2) h = 1;
                end else begin
                    if (age == 1 && (wr_log[i].load || d.is_branch)) h = 1;
                    if (age == 2 && wr_log[i].load && d.is_branch) h = 1;
                end
            end
        end
        return d.valid && h;
    endfunction

    task automatic drive(input dec_t d);
        bus.id_valid     = d.valid;
        bus.id_rs_addr   = d.rs;
        bus.id_rs_used   = d.rs_used;
        bus.id_rt_addr   = d.rt;
        bus.id_rt_used   = d.rt_used;
        bus.id_rd_addr   = d.rd;
        bus.id_reg_write = d.reg_write;
        bus.id_mem_read  = d.mem_read;
        bus.id_branch    = d.branch;
        bus.id_is_branch = d.is_branch;
        bus.id_halt      = d.halt;
        bus.id_err       = d.err;
    endtask

    // One clock cycle: apply inputs, predict outputs, advance the model
    task automatic tick(input dec_t d, input bit rst_v, output bit stall_m);
        exp_t e;
        bit   run;
        bit   hz;
        @(posedge clk);
        #1;
        rst = rst_v;
        drive(d);
        e = '{0, 0, 0, 0, 0};
        if (!rst_v) begin
            wr_log.delete();
            drain_at = -1;
            m_err    = 0;
        end else begin
            run   = (drain_at < 0) || (cyc < drain_at);
            e.err = m_err;
            if (run) begin
                hz       = model_hazard(d);
                e.stall  = hz;
                e.bubble = hz;
                e.flush  = d.valid && d.branch && !hz;
                if (d.valid && d.reg_write && !hz)
                    wr_log.push_back('{cyc, d.rd, d.mem_read});
                if (d.valid && (d.halt || d.err) && !hz) begin
                    drain_at = cyc + 1;
                    if (d.err) m_err = 1;
                end
            end else begin
                e.stall  = 1;
                e.bubble = 1;
                e.halt   = (cyc >= drain_at + 3);
            end
        end
        stall_m = e.stall;
        exp_q.push_back(e);
        cyc++;
        while (wr_log.size() > 0 && cyc - wr_log[0].cyc > 2)
            void'(wr_log.pop_front());
    endtask

    // Present one instruction, holding it in decode while the model stalls it
    task automatic issue(input dec_t d, input int want_stall, input int want_flush, input string nm);
        bit s;
        int n_st = 0;
        int n_fl = 0;
        int guard = 0;
        do begin
            tick(d, 1'b1, s);
            #2;
            if (bus.stall_if === 1'b1) n_st++;
            if (bus.flush_if === 1'b1) n_fl++;
            guard++;
        end while (s && guard < 8);
        chk_int({nm, "_stalls"}, n_st, want_stall);
        chk_int({nm, "_flushes"}, n_fl, want_flush);
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) tick(nop(), 1'b1, s);
    endtask

    task automatic do_reset();
        bit s;
        tick(nop(), 1'b0, s);
        tick(nop(), 1'b0, s);
        tick(nop(), 1'b1, s);
    endtask

    // Monitor: every cycle, compare DUT controls against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_if",  bus.stall_if,  e.stall);
            chk("bubble_ex", bus.bubble_ex, e.bubble);
            chk("flush_if",  bus.flush_if,  e.flush);
            chk("halt",      bus.halt,      e.halt);
            chk("err",       bus.err,       e.err);
        end
        mon_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   s;
        dec_t d;
        int   first_halt;
        drive(nop());
        do_reset();

        issue(alu(1, 2, 3), 0, 0, "add_r1");
        issue(alu(2, 1, 3), FWD ? 0 : 2, 0, "raw_alu");
        idle(3);

        issue(ld(4, 0), 0, 0, "ld_r4");
        issue(alu(5, 4, 4), FWD ? 1 : 2, 0, "load_use");
        idle(3);

        issue(br(1, 1), 0, 1, "br_clean");
        idle(1);
        issue(alu(1, 2, 3), 0, 0, "add_before_br");
        issue(br(1, 1), FWD ? 1 : 2, 1, "br_after_add");
        idle(3);

        issue(alu(3, 0, 0), 0, 0, "add_r3");
        d = alu(6, 3, 5);
        d.rs_used = 0;
        issue(d, 0, 0, "rs_unused");
        idle(3);

        // Halt, error and both together: 3 drain cycles then halted
        for (int v = 0; v < 3; v++) begin
            tick(stop(v != 1, v != 0), 1'b1, s);
            first_halt = 0;
            for (int i = 1; i <= 6; i++) begin
                tick(nop(), 1'b1, s);
                #2;
                if (i == 1) chk("drain_stall_next", bus.stall_if, 1'b1);
                if (first_halt == 0 && bus.halt === 1'b1) first_halt = i;
            end
            chk_int("halt_latency", first_halt, 4);
            chk("sticky_err", bus.err, (v != 0) ? 1'b1 : 1'b0);
            do_reset();
        end

        // Reset asserted in the second drain cycle
        tick(stop(1, 0), 1'b1, s);
        tick(nop(), 1'b1, s);
        tick(nop(), 1'b0, s);
        #2;
        chk("rst_drain_stall", bus.stall_if, 1'b0);
        chk("rst_drain_halt", bus.halt, 1'b0);
        tick(nop(), 1'b0, s);
        tick(nop(), 1'b1, s);
        issue(alu(1, 2, 3), 0, 0, "post_rst_add");
        idle(2);

        // Randomized traffic, resetting once halted or occasionally at random
        for (int k = 0; k < 400; k++) begin
            bit rv;
            d = nop();
            d.valid     = ($urandom_range(0, 4) != 0);
            d.rs        = 3'($urandom_range(0, 3));
            d.rt        = 3'($urandom_range(0, 3));
            d.rd        = 3'($urandom_range(0, 3));
            d.rs_used   = 1'($urandom_range(0, 1));
            d.rt_used   = 1'($urandom_range(0, 1));
            d.reg_write = ($urandom_range(0, 3) != 0);
            d.mem_read  = ($urandom_range(0, 2) == 0);
            d.branch    = ($urandom_range(0, 3) == 0);
            d.is_branch = d.branch || ($urandom_range(0, 7) == 0);
            d.halt      = ($urandom_range(0, 59) == 0);
            d.err       = ($urandom_range(0, 89) == 0);
            rv = !((drain_at >= 0 && cyc >= drain_at + 4) || $urandom_range(0, 149) == 0);
            tick(d, rv, s);
        end
        tick(nop(), 1'b1, s);

        repeat (3) @(negedge clk);
        #1;
        chk_int("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
